mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Sits between the CPU core and the unified MEMORY block. Arbitrates one instruction-fetch port and one data port
//  onto MEMORY's single address/read/write port. Handles byte/halfword loads (lane extract, sign/zero extend).
//  Handles sub-word stores to DRAM by read-modify-write; MEMORY itself only writes whole words.
// PARAMETERS
//  WIDTH        32           data/address width (matches `WIDTH)
//  DEV_BASE     32'h0000_2000 first address of device region (no RMW at or above)
// PORTS
//  clk          in   1   single clock, all state on posedge
//  rst          in   1   synchronous, active-high reset
//  if_req_i     in   1   fetch request; addr held until if_valid_o
//  if_addr_i    in   32  fetch byte address, word aligned
//  if_valid_o   out  1   1-cycle pulse, if_rdata_o valid
//  if_rdata_o   out  32  fetched instruction word
//  d_req_i      in   1   data request; all d_* inputs held until d_done_o
//  d_we_i       in   1   1=store, 0=load
//  d_size_i     in   2   0=byte 1=half 2=word (3 treated as word)
//  d_unsigned_i in   1   loads: 1=zero-extend, 0=sign-extend
//  d_addr_i     in   32  data byte address
//  d_wdata_i    in   32  store data, right-justified
//  d_done_o     out  1   1-cycle pulse, access complete
//  d_rdata_o    out  32  extended load data, valid with d_done_o
//  d_misalign_o out  1   with d_done_o: access rejected, no memory side effect
//  memread_o    out  1   to MEMORY memread_i
//  memwrite_o   out  1   to MEMORY memwrite_i
//  memaddr_o    out  32  to MEMORY memaddr_i, always {addr[31:2],2'b00}
//  memwdata_o   out  32  to MEMORY memwdata_i
//  memrdata_i   in   32  from MEMORY, valid one cycle after memread_o
// BEHAVIOUR
//  - Reset: state IDLE; every output 0; captured lane/size regs 0.
//  - FSM states: IDLE, IF_WAIT, LD_WAIT, RMW_RD, RMW_WR, MIS.
//  - IDLE priority: d_req_i > if_req_i. Grants are sampled only in IDLE; no preemption mid-access.
//  - Misalign check: half with addr[0]=1, or word with addr[1:0]!=0 -> MIS (no mem strobe), d_done_o+d_misalign_o next cycle.
//  - Fetch: IDLE drives memread_o=1, addr -> IF_WAIT. Next cycle: if_valid_o=1, if_rdata_o=memrdata_i, -> IDLE. Latency 2.
//  - Load: IDLE memread_o=1 -> LD_WAIT. Next cycle: select lane by addr[1:0], extend, d_done_o=1 -> IDLE. Latency 2.
//  - Word store, or any store with addr >= DEV_BASE: IDLE drives memwrite_o=1, wdata (sub-word zero-extended, unshifted).
//    d_done_o is asserted the following cycle; the FSM passes through RMW_WR with no strobe, then returns to IDLE.
//  - Sub-word store below DEV_BASE: IDLE memread_o=1 -> RMW_RD. RMW_RD latches memrdata_i into the merge reg -> RMW_WR.
//    RMW_WR drives memwrite_o=1 with merged word, byte lanes replaced per addr[1:0]/size. d_done_o the following cycle.
//    Latency 3; the same memaddr_o is held across all phases.
//  - Byte lane n = bits [8n+7:8n], little-endian. Half lane uses addr[1]. Lane extract/merge are purely combinational on regs.
//  - memread_o and memwrite_o are never high together. They are high exactly one cycle per issue.
//  - Fetch never observes write-cycle data: MEMORY returns IROM data during writes, and that data is discarded.
//  - Output timing: all outputs to MEMORY are registered (FSM-issue cycle = one cycle after grant). if_*/d_* outputs are
//    registered pulses.
//  - Request dropped mid-access: the access completes anyway, and its done/valid pulse is still issued.
//  - Reset mid-access: the access is abandoned, outputs go to 0 the next cycle, and no write is issued.
//  - Simultaneous if_req_i and d_req_i: data is served first. Fetch is granted on the next IDLE cycle if still requested.
// STRUCTURE
//  - Shared defines.v gains: `SZ_BYTE/`SZ_HALF/`SZ_WORD, state encodings `MA_IDLE.. `MA_MIS, `DEV_BASE.
//  - One natural sub-module: lane_unit, a combinational load-extract plus store-merge keyed by addr[1:0], size, unsigned.
//  - The top level holds the FSM, the captured request regs, and the merge register.
// TESTING
//  - Fetch 0x0000_0010, memrdata=0x1234_5678 -> memread pulse, addr 0x10; if_valid 2 cycles later, rdata 0x1234_5678.
//  - LB signed addr 0x1003, mem word 0x80FF_0000 -> d_rdata 0xFFFF_FF80; LBU -> 0x0000_0080.
//  - SB 0xAB to 0x1001, mem word 0x1122_3344 -> one read, then write 0x1122_AB44 to 0x1000; no other write.
//  - SH to 0x1001 -> d_done + d_misalign, memread/memwrite stay 0. SW to 0xFFFF_FFF0 val 0x1234 -> single write, no read.
//  - if_req and d_req (LW 0x1000) in same cycle -> data served first, then fetch; the two strobes never overlap.
//  - rst asserted in RMW_RD -> no memwrite_o ever; outputs 0 next cycle; the next request is served normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: access sizes, FSM states,
// device-region base and small decode helpers.
package mem_arbiter_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [31:0] DEV_BASE_DEFAULT = 32'h0000_2000;

    typedef enum logic [2:0] {
        MA_IDLE,
        MA_IF_WAIT,
        MA_LD_WAIT,
        MA_RMW_RD,
        MA_RMW_WR,
        MA_MIS
    } ma_state_t;

    // Size code 3 behaves exactly like a word access.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        if (is_word(size))
            return offset != 2'b00;
        else if (size == SZ_HALF)
            return offset[0];
        else
            return 1'b0;
    endfunction

    function automatic logic [31:0] zext_store(input logic [1:0] size, input logic [31:0] data);
        if (is_word(size))
            return data;
        else if (size == SZ_HALF)
            return {16'h0000, data[15:0]};
        else
            return {24'h00_0000, data[7:0]};
    endfunction

endpackage

// File: rtl/mem_arbiter_lane_unit.sv
// Combinational byte-lane logic: load extract with sign/zero extension and
// sub-word store merge into a previously read word, keyed by offset and size.
module lane_unit
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] load_word,
    input  logic [31:0] store_data,
    input  logic [31:0] merge_word,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = load_word[{offset, 3'b000} +: 8];
        half_sel  = offset[1] ? load_word[31:16] : load_word[15:0];
        load_data = load_word;
        if (size == SZ_BYTE)
            load_data = is_unsigned ? {24'h00_0000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        else if (size == SZ_HALF)
            load_data = is_unsigned ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
    end

    always_comb begin
        merged_word = merge_word;
        if (is_word(size))
            merged_word = store_data;
        else if (size == SZ_HALF)
            merged_word[{offset[1], 4'b0000} +: 16] = store_data[15:0];
        else
            merged_word[{offset, 3'b000} +: 8] = store_data[7:0];
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data ports onto the single MEMORY port; sub-word
// DRAM stores are done as read-modify-write, device stores go straight out.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int                WIDTH    = 32,
    parameter logic [WIDTH-1:0]  DEV_BASE = DEV_BASE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req_i,
    input  logic [WIDTH-1:0] if_addr_i,
    output logic             if_valid_o,
    output logic [WIDTH-1:0] if_rdata_o,
    input  logic             d_req_i,
    input  logic             d_we_i,
    input  logic [1:0]       d_size_i,
    input  logic             d_unsigned_i,
    input  logic [WIDTH-1:0] d_addr_i,
    input  logic [WIDTH-1:0] d_wdata_i,
    output logic             d_done_o,
    output logic [WIDTH-1:0] d_rdata_o,
    output logic             d_misalign_o,
    output logic             memread_o,
    output logic             memwrite_o,
    output logic [WIDTH-1:0] memaddr_o,
    output logic [WIDTH-1:0] memwdata_o,
    input  logic [WIDTH-1:0] memrdata_i
);

    ma_state_t        state;
    logic             phase;
    logic [1:0]       cap_offset;
    logic [1:0]       cap_size;
    logic             cap_unsigned;
    logic [WIDTH-1:0] cap_wdata;
    logic [WIDTH-1:0] merge_reg;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] merged_word;

    lane_unit u_lane (
        .offset      (cap_offset),
        .size        (cap_size),
        .is_unsigned (cap_unsigned),
        .load_word   (memrdata_i),
        .store_data  (cap_wdata),
        .merge_word  (merge_reg),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // Read data arrives the cycle after the strobe, so each wait state spends
    // one cycle with phase=0 before sampling memrdata_i with phase=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= MA_IDLE;
            phase        <= 1'b0;
            cap_offset   <= '0;
            cap_size     <= '0;
            cap_unsigned <= 1'b0;
            cap_wdata    <= '0;
            merge_reg    <= '0;
            if_valid_o   <= 1'b0;
            if_rdata_o   <= '0;
            d_done_o     <= 1'b0;
            d_rdata_o    <= '0;
            d_misalign_o <= 1'b0;
            memread_o    <= 1'b0;
            memwrite_o   <= 1'b0;
            memaddr_o    <= '0;
            memwdata_o   <= '0;
        end else begin
            memread_o    <= 1'b0;
            memwrite_o   <= 1'b0;
            if_valid_o   <= 1'b0;
            d_done_o     <= 1'b0;
            d_misalign_o <= 1'b0;
            case (state)
                MA_IDLE: begin
                    phase <= 1'b0;
                    if (d_req_i) begin
                        cap_offset   <= d_addr_i[1:0];
                        cap_size     <= d_size_i;
                        cap_unsigned <= d_unsigned_i;
                        cap_wdata    <= d_wdata_i;
                        if (is_misaligned(d_size_i, d_addr_i[1:0])) begin
                            state <= MA_MIS;
                        end else begin
                            memaddr_o <= d_addr_i & ~WIDTH'(3);
                            if (!d_we_i) begin
                                memread_o <= 1'b1;
                                state     <= MA_LD_WAIT;
                            end else if (is_word(d_size_i) || d_addr_i >= DEV_BASE) begin
                                memwrite_o <= 1'b1;
                                memwdata_o <= zext_store(d_size_i, d_wdata_i);
                                phase      <= 1'b1;
                                state      <= MA_RMW_WR;
                            end else begin
                                memread_o <= 1'b1;
                                state     <= MA_RMW_RD;
                            end
                        end
                    end else if (if_req_i) begin
                        memread_o <= 1'b1;
                        memaddr_o <= if_addr_i & ~WIDTH'(3);
                        state     <= MA_IF_WAIT;
                    end
                end
                MA_IF_WAIT: begin
                    if (!phase) begin
                        phase <= 1'b1;
                    end else begin
                        if_valid_o <= 1'b1;
                        if_rdata_o <= memrdata_i;
                        state      <= MA_IDLE;
                    end
                end
                MA_LD_WAIT: begin
                    if (!phase) begin
                        phase <= 1'b1;
                    end else begin
                        d_done_o  <= 1'b1;
                        d_rdata_o <= load_data;
                        state     <= MA_IDLE;
                    end
                end
                MA_RMW_RD: begin
                    if (!phase) begin
                        phase <= 1'b1;
                    end else begin
                        merge_reg <= memrdata_i;
                        phase     <= 1'b0;
                        state     <= MA_RMW_WR;
                    end
                end
                // phase=0 issues the merged write; phase=1 (also entered directly
                // by word/device stores) only reports completion.
                MA_RMW_WR: begin
                    if (!phase) begin
                        memwrite_o <= 1'b1;
                        memwdata_o <= merged_word;
                        phase      <= 1'b1;
                    end else begin
                        d_done_o <= 1'b1;
                        state    <= MA_IDLE;
                    end
                end
                MA_MIS: begin
                    d_done_o     <= 1'b1;
                    d_misalign_o <= 1'b1;
                    state        <= MA_IDLE;
                end
                default: state <= MA_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency MEMORY model and
// strobe monitors counting reads, writes and read/write overlaps.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_valid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [1:0]  d_size_i;
    logic        d_unsigned_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_done_o;
    logic [31:0] d_rdata_o;
    logic        d_misalign_o;
    logic        memread_o;
    logic        memwrite_o;
    logic [31:0] memaddr_o;
    logic [31:0] memwdata_o;
    logic [31:0] memrdata_i = 32'h0;

    logic [31:0] mem_word = 32'h0;
    int rd_count = 0;
    int wr_count = 0;
    int overlap_count = 0;
    int rd_base;
    int wr_base;
    int evaluated = 0;
    int failures = 0;

    mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_valid_o   (if_valid_o),
        .if_rdata_o   (if_rdata_o),
        .d_req_i      (d_req_i),
        .d_we_i       (d_we_i),
        .d_size_i     (d_size_i),
        .d_unsigned_i (d_unsigned_i),
        .d_addr_i     (d_addr_i),
        .d_wdata_i    (d_wdata_i),
        .d_done_o     (d_done_o),
        .d_rdata_o    (d_rdata_o),
        .d_misalign_o (d_misalign_o),
        .memread_o    (memread_o),
        .memwrite_o   (memwrite_o),
        .memaddr_o    (memaddr_o),
        .memwdata_o   (memwdata_o),
        .memrdata_i   (memrdata_i)
    );

    always #5 clk = ~clk;

    // Read data for a strobe appears the following cycle; otherwise junk.
    always @(posedge clk)
        memrdata_i <= memread_o ? mem_word : 32'hDEAD_BEEF;

    always @(negedge clk) begin
        if (memread_o) rd_count <= rd_count + 1;
        if (memwrite_o) wr_count <= wr_count + 1;
        if (memread_o && memwrite_o) overlap_count <= overlap_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        evaluated++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic data_req(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata);
        d_req_i      = 1'b1;
        d_we_i       = we;
        d_size_i     = size;
        d_unsigned_i = uns;
        d_addr_i     = addr;
        d_wdata_i    = wdata;
    endtask

    task automatic snapshot();
        rd_base = rd_count;
        wr_base = wr_count;
    endtask

    initial begin
        rst = 1'b1; if_req_i = 1'b0; if_addr_i = '0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_size_i = '0; d_unsigned_i = 1'b0;
        d_addr_i = '0; d_wdata_i = '0;
        tick(); tick();
        check_output("reset memread", {31'b0, memread_o}, 32'h0);
        check_output("reset memwrite", {31'b0, memwrite_o}, 32'h0);
        check_output("reset memaddr", memaddr_o, 32'h0);
        check_output("reset done", {29'b0, d_done_o, d_misalign_o, if_valid_o}, 32'h0);
        check_output("reset rdata", d_rdata_o | if_rdata_o | memwdata_o, 32'h0);
        rst = 1'b0;
        tick();

        $display("[TB] fetch 0x10");
        snapshot();
        mem_word = 32'h1234_5678; if_req_i = 1'b1; if_addr_i = 32'h0000_0010;
        tick();
        if_req_i = 1'b0;
        check_output("fetch memread", {31'b0, memread_o}, 32'h1);
        check_output("fetch memaddr", memaddr_o, 32'h0000_0010);
        tick();
        check_output("fetch early valid", {31'b0, if_valid_o}, 32'h0);
        tick();
        check_output("fetch valid", {31'b0, if_valid_o}, 32'h1);
        check_output("fetch rdata", if_rdata_o, 32'h1234_5678);
        tick();
        check_output("fetch valid pulse", {31'b0, if_valid_o}, 32'h0);
        check_output("fetch reads", rd_count - rd_base, 32'h1);

        $display("[TB] LB / LBU 0x1003");
        mem_word = 32'h80FF_0000;
        data_req(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0);
        tick(); d_req_i = 1'b0;
        check_output("lb memaddr", memaddr_o, 32'h0000_1000);
        tick(); tick();
        check_output("lb done", {31'b0, d_done_o}, 32'h1);
        check_output("lb rdata", d_rdata_o, 32'hFFFF_FF80);
        data_req(1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0);
        tick(); d_req_i = 1'b0; tick(); tick();
        check_output("lbu rdata", d_rdata_o, 32'h0000_0080);

        $display("[TB] LH / LHU 0x1002");
        mem_word = 32'h8001_1234;
        data_req(1'b0, 2'd1, 1'b0, 32'h0000_1002, 32'h0);
        tick(); d_req_i = 1'b0; tick(); tick();
        check_output("lh rdata", d_rdata_o, 32'hFFFF_8001);
        data_req(1'b0, 2'd1, 1'b1, 32'h0000_1000, 32'h0);
        tick(); d_req_i = 1'b0; tick(); tick();
        check_output("lhu low rdata", d_rdata_o, 32'h0000_1234);

        $display("[TB] SB 0xAB to 0x1001 (RMW)");
        snapshot();
        mem_word = 32'h1122_3344;
        data_req(1'b1, 2'd0, 1'b0, 32'h0000_1001, 32'h0000_00AB);
        tick(); d_req_i = 1'b0;
        check_output("sb rmw read", {30'b0, memread_o, memwrite_o}, 32'h2);
        check_output("sb rmw rd addr", memaddr_o, 32'h0000_1000);
        tick(); tick();
        check_output("sb no early write", {31'b0, memwrite_o}, 32'h0);
        tick();
        check_output("sb write strobe", {30'b0, memread_o, memwrite_o}, 32'h1);
        check_output("sb merged data", memwdata_o, 32'h1122_AB44);
        check_output("sb wr addr", memaddr_o, 32'h0000_1000);
        tick();
        check_output("sb done", {30'b0, d_done_o, d_misalign_o}, 32'h2);
        tick();
        check_output("sb reads", rd_count - rd_base, 32'h1);
        check_output("sb writes", wr_count - wr_base, 32'h1);

        $display("[TB] SH misaligned 0x1001");
        snapshot();
        data_req(1'b1, 2'd1, 1'b0, 32'h0000_1001, 32'h0000_BEEF);
        tick(); d_req_i = 1'b0;
        check_output("sh mis no strobe", {30'b0, memread_o, memwrite_o}, 32'h0);
        tick();
        check_output("sh mis done", {30'b0, d_done_o, d_misalign_o}, 32'h3);
        tick();
        check_output("sh mis mem untouched", (rd_count - rd_base) + (wr_count - wr_base), 32'h0);

        $display("[TB] SW 0xFFFFFFF0 and SB to device 0x2004");
        snapshot();
        data_req(1'b1, 2'd2, 1'b0, 32'hFFFF_FFF0, 32'h0000_1234);
        tick(); d_req_i = 1'b0;
        check_output("sw write strobe", {30'b0, memread_o, memwrite_o}, 32'h1);
        check_output("sw addr", memaddr_o, 32'hFFFF_FFF0);
        check_output("sw data", memwdata_o, 32'h0000_1234);
        tick();
        check_output("sw done", {30'b0, d_done_o, d_misalign_o}, 32'h2);
        data_req(1'b1, 2'd0, 1'b0, 32'h0000_2004, 32'h0000_01FF);
        tick(); d_req_i = 1'b0;
        check_output("dev sb data", memwdata_o, 32'h0000_00FF);
        check_output("dev sb addr", memaddr_o, 32'h0000_2004);
        tick();
        check_output("dev sb done", {31'b0, d_done_o}, 32'h1);
        tick();
        check_output("direct stores no read", rd_count - rd_base, 32'h0);
        check_output("direct stores writes", wr_count - wr_base, 32'h2);

        $display("[TB] simultaneous fetch and LW");
        mem_word = 32'hCAFE_F00D;
        if_req_i = 1'b1; if_addr_i = 32'h0000_0020;
        data_req(1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0);
        tick();
        check_output("arb data first", memaddr_o, 32'h0000_1000);
        tick(); tick();
        check_output("arb lw done", {30'b0, d_done_o, if_valid_o}, 32'h2);
        check_output("arb lw rdata", d_rdata_o, 32'hCAFE_F00D);
        d_req_i = 1'b0;
        tick();
        check_output("arb fetch issue", {31'b0, memread_o}, 32'h1);
        check_output("arb fetch addr", memaddr_o, 32'h0000_0020);
        mem_word = 32'h0BAD_C0DE;
        tick(); tick();
        check_output("arb fetch valid", {31'b0, if_valid_o}, 32'h1);
        check_output("arb fetch rdata", if_rdata_o, 32'h0BAD_C0DE);
        if_req_i = 1'b0;
        tick();
        check_output("no strobe overlap", overlap_count, 32'h0);

        $display("[TB] reset during RMW_RD");
        snapshot();
        mem_word = 32'h5566_7788;
        data_req(1'b1, 2'd0, 1'b0, 32'h0000_1002, 32'h0000_0055);
        tick();
        rst = 1'b1; d_req_i = 1'b0;
        tick();
        rst = 1'b0;
        check_output("rst mid outputs", {29'b0, memread_o, memwrite_o, d_done_o}, 32'h0);
        check_output("rst mid memaddr", memaddr_o, 32'h0);
        tick(); tick(); tick(); tick();
        check_output("rst mid no write", wr_count - wr_base, 32'h0);
        check_output("rst mid no done", {31'b0, d_done_o}, 32'h0);
        mem_word = 32'h0102_0304;
        data_req(1'b0, 2'd2, 1'b0, 32'h0000_1004, 32'h0);
        tick(); d_req_i = 1'b0;
        check_output("post rst lw addr", memaddr_o, 32'h0000_1004);
        tick(); tick();
        check_output("post rst lw done", {31'b0, d_done_o}, 32'h1);
        check_output("post rst lw rdata", d_rdata_o, 32'h0102_0304);

        $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
        $finish;
    end

endmodule
